// File: rtl/gate_sweep_pkg.sv
// Shared encodings for the gate sweep checker.
// Golden op selects and sweep FSM states.
package gate_sweep_pkg;

  localparam logic [1:0] OP_NAND = 2'd0;
  localparam logic [1:0] OP_NOR  = 2'd1;
  localparam logic [1:0] OP_AND  = 2'd2;
  localparam logic [1:0] OP_XOR  = 2'd3;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_HOLD = 2'd1;
  localparam state_t S_DONE = 2'd2;

endpackage

// File: rtl/gate_sweep_checker_gate_ref.sv
// gate_ref: combinational golden model of the swept gate.
// Reduces all stim bits with the selected function.
module gate_ref
  import gate_sweep_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [N_IN-1:0] stim,
  input  logic [1:0]      op,
  output logic            expected
);

  always_comb begin
    expected = 1'b0;
    unique case (op)
      OP_NAND: expected = ~&stim;
      OP_NOR:  expected = ~|stim;
      OP_AND:  expected = &stim;
      OP_XOR:  expected = ^stim;
      default: expected = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive self-checking sweep engine for N-input gates.
// Define GATE_SWEEP_STOP_ON_ERR_EN to end the sweep at first mismatch.
module gate_sweep_checker
  import gate_sweep_pkg::*;
#(
  parameter int N_IN        = 2,
  parameter int HOLD_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op_sel,
  input  logic            dut_out,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] first_err_vec,
  output logic            first_err_valid
);

  localparam int HW =
    (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HMAX = HW'(HOLD_CYCLES - 1);

  state_t        state;
  logic [1:0]    op_q;
  logic [HW-1:0] hcnt;
  logic          exp_bit;
  logic          last;
  logic          mis;
  logic [N_IN:0] err_next;

  gate_ref #(.N_IN(N_IN)) u_ref (
    .stim     (stim),
    .op       (op_q),
    .expected (exp_bit)
  );

  assign last     = (hcnt == HMAX);
  assign mis      = last && (dut_out != exp_bit);
  assign err_next = err_cnt + (N_IN+1)'(mis);
  assign busy     = (state == S_HOLD);
  assign done     = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      op_q            <= OP_NAND;
      hcnt            <= '0;
      stim            <= '0;
      pass            <= 1'b0;
      err_cnt         <= '0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            op_q            <= op_sel;
            err_cnt         <= '0;
            pass            <= 1'b0;
            first_err_valid <= 1'b0;
            stim            <= '0;
            hcnt            <= '0;
            state           <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!last) begin
            hcnt <= hcnt + HW'(1);
          end else begin
            hcnt    <= '0;
            err_cnt <= err_next;
            if (mis && !first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_vec   <= stim;
            end
`ifdef GATE_SWEEP_STOP_ON_ERR_EN
            if (mis || (&stim)) begin
`else
            if (&stim) begin
`endif
              pass  <= (err_next == '0);
              state <= S_DONE;
            end else begin
              stim <= stim + N_IN'(1);
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Randomized bench for gate_sweep_checker against a
// popcount-based reference of the sweep outcome.
module tb_gate_sweep_checker;

  localparam int N  = 3;
  localparam int H  = 2;
  localparam int NV = 1 << N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   op_sel;
  logic         dut_out;
  logic [N-1:0] stim;
  logic         busy;
  logic         done;
  logic         pass;
  logic [N:0]   err_cnt;
  logic [N-1:0] first_err_vec;
  logic         first_err_valid;

  logic [NV-1:0] resp;

  int checks = 0;
  int errors = 0;

  gate_sweep_checker #(
    .N_IN        (N),
    .HOLD_CYCLES (H)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .op_sel          (op_sel),
    .dut_out         (dut_out),
    .stim            (stim),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_cnt         (err_cnt),
    .first_err_vec   (first_err_vec),
    .first_err_valid (first_err_valid)
  );

  always #5 clk = ~clk;

  assign dut_out = resp[stim];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic gold(input logic [1:0] op,
                                input logic [N-1:0] v);
    int p;
    p = $countones(v);
    case (op)
      2'd0:    return p != N;
      2'd1:    return p == 0;
      2'd2:    return p == N;
      default: return p % 2 == 1;
    endcase
  endfunction

  // mode: 0 correct, 1 stuck-at-0, 2 AND gate, 3 random faults
  task automatic run_sweep(input logic [1:0] op,
                           input int mode);
    int exp_err;
    int exp_first;
    int exp_done;
    int exp_stim;
    int cyc;
    bit got;
    for (int v = 0; v < NV; v++) begin
      logic g;
      g = gold(op, N'(v));
      case (mode)
        0:       resp[v] = g;
        1:       resp[v] = 1'b0;
        2:       resp[v] = (v == NV - 1);
        default: resp[v] = g ^ ($urandom_range(3) == 0);
      endcase
    end
    exp_err   = 0;
    exp_first = -1;
    for (int v = 0; v < NV; v++) begin
      if (resp[v] != gold(op, N'(v))) begin
        exp_err++;
        if (exp_first < 0) exp_first = v;
      end
    end
    exp_done = NV * H;
    exp_stim = NV - 1;
`ifdef GATE_SWEEP_STOP_ON_ERR_EN
    if (exp_first >= 0) begin
      exp_err  = 1;
      exp_done = (exp_first + 1) * H;
      exp_stim = exp_first;
    end
`endif
    @(negedge clk);
    start  = 1'b1;
    op_sel = op;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_busy", 32'(busy), 1);
    check("start_stim", 32'(stim), 0);
    check("start_err", 32'(err_cnt), 0);
    check("start_fev", 32'(first_err_valid), 0);
    op_sel = 2'($urandom);
    cyc = 0;
    got = 0;
    while (!got && cyc < exp_done + 8) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) got = 1;
      else check("stim_trace", 32'(stim), 32'(cyc / H));
      start = (cyc == 2) && !done;
    end
    start = 1'b0;
    check("done_cycle", got ? 32'(cyc) : 32'hffffffff,
          32'(exp_done));
    check("err_cnt", 32'(err_cnt), 32'(exp_err));
    check("pass", 32'(pass), 32'(exp_err == 0));
    check("fev", 32'(first_err_valid), 32'(exp_first >= 0));
    if (exp_first >= 0)
      check("fvec", 32'(first_err_vec), 32'(exp_first));
    check("done_busy", 32'(busy), 0);
    check("end_stim", 32'(stim), 32'(exp_stim));
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("done_pulse", 32'(done), 0);
    check("no_requeue", 32'(busy), 0);
    check("pass_sticky", 32'(pass), 32'(exp_err == 0));
    check("err_held", 32'(err_cnt), 32'(exp_err));
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    op_sel = 2'd0;
    resp   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stim", 32'(stim), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_err", 32'(err_cnt), 0);
    check("rst_fvec", 32'(first_err_vec), 0);
    check("rst_fev", 32'(first_err_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_sweep(2'd0, 0);
    run_sweep(2'd0, 1);
    run_sweep(2'd0, 2);
    run_sweep(2'd2, 2);
    run_sweep(2'd1, 0);
    run_sweep(2'd3, 0);
    run_sweep(2'd1, 1);
    for (int i = 0; i < 8; i++)
      run_sweep(2'($urandom), 3);

    // abort mid-sweep with errors already counted
    for (int v = 0; v < NV; v++) resp[v] = 1'b0;
    @(negedge clk);
    start  = 1'b1;
    op_sel = 2'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2 * H + 1) @(posedge clk);
    #1;
    check("pre_abort_err", 32'(err_cnt != 0), 1);
    rst_n = 1'b0;
    #1;
    check("abort_stim", 32'(stim), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_err", 32'(err_cnt), 0);
    check("abort_fev", 32'(first_err_valid), 0);
    check("abort_fvec", 32'(first_err_vec), 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("abort_nodone", 32'(done), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(2'd3, 0);
    run_sweep(2'd0, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
